sequenciador_entrada: RTL and testbench

//   Upstream stage of the 5-bit to 7-segment decoder: produces the 5-bit code that

---
 rtl/sequenciador_entrada.sv | 125 ++++++++++++
 tb/tb_sequenciador_entrada.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_entrada.sv
// Code sequencer ahead of the 5-bit 7-segment decoder: auto-advance from a prescaled tick,
// manual step from a debounced button, direct load, and a one-cycle change pulse.
module sequenciador_entrada #(
    parameter int unsigned DIV_TICK     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       habilita,
    input  logic       sentido,
    input  logic       passo,
    input  logic       carrega,
    input  logic [0:4] valor_carga,
    output logic [0:4] codigo,
    output logic       novo
);

    localparam int unsigned PW = $clog2(DIV_TICK);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV_TICK - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        StOcioso,
        StFiltrando,
        StPressionado,
        StLiberando
    } estado_t;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic          sync1_q, ps_q;
    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          passo_ok;
    logic [0:4]    codigo_q, codigo_d;
    logic          novo_q, novo_d;

    // Prescaler: a load restarts the tick period from zero.
    always_comb begin
        tick = habilita && (pre_q == PRE_MAX);
        if (!habilita || carrega || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        passo_ok = 1'b0;
        unique case (estado_q)
            StOcioso: begin
                if (ps_q) begin
                    estado_d = StFiltrando;
                    cnt_d    = '0;
                end
            end
            StFiltrando: begin
                if (!ps_q) begin
                    estado_d = StOcioso;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = StPressionado;
                    passo_ok = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StPressionado: begin
                if (!ps_q) begin
                    estado_d = StLiberando;
                    cnt_d    = '0;
                end
            end
            StLiberando: begin
                if (ps_q) begin
                    estado_d = StPressionado;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = StOcioso;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: estado_d = StOcioso;
        endcase
    end

    // Load wins over step and tick; a simultaneous step and tick give a single step.
    always_comb begin
        codigo_d = codigo_q;
        novo_d   = 1'b0;
        if (carrega) begin
            codigo_d = valor_carga;
            novo_d   = 1'b1;
        end else if (passo_ok || tick) begin
            codigo_d = sentido ? codigo_q + 5'd1 : codigo_q - 5'd1;
            novo_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            sync1_q  <= 1'b0;
            ps_q     <= 1'b0;
            estado_q <= StOcioso;
            cnt_q    <= '0;
            codigo_q <= '0;
            novo_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            sync1_q  <= passo;
            ps_q     <= sync1_q;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            codigo_q <= codigo_d;
            novo_q   <= novo_d;
        end
    end

    assign codigo = codigo_q;
    assign novo   = novo_q;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Bench for sequenciador_entrada: directed scenarios plus random stimulus against an
// event-level reference model of tick period, button debounce and code stepping.
module tb_sequenciador_entrada;

    localparam int DIV = 4;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       habilita = 1'b0;
    logic       sentido = 1'b0;
    logic       passo = 1'b0;
    logic       carrega = 1'b0;
    logic [0:4] valor_carga = '0;
    logic [0:4] codigo;
    logic       novo;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_code, hab_run, hi_run, lo_run;
    bit armed, p_d1, p_d2, m_novo;

    sequenciador_entrada #(
        .DIV_TICK    (DIV),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .habilita   (habilita),
        .sentido    (sentido),
        .passo      (passo),
        .carrega    (carrega),
        .valor_carga(valor_carga),
        .codigo     (codigo),
        .novo       (novo)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_code  = 0;
        m_novo  = 0;
        hab_run = 0;
        hi_run  = 0;
        lo_run  = 0;
        armed   = 1;
        p_d1    = 0;
        p_d2    = 0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic ciclo();
        bit s, fire, tk;
        @(posedge clk);
        s    = p_d2;
        p_d2 = p_d1;
        p_d1 = passo;
        if (s) begin
            hi_run++;
            lo_run = 0;
        end else begin
            lo_run++;
            hi_run = 0;
        end
        // A press counts after DEB+1 steady high samples, once per release of DEB+1 low samples.
        fire = armed && s && (hi_run == DEB + 1);
        if (fire) armed = 0;
        if (!armed && !s && (lo_run == DEB + 1)) armed = 1;
        tk      = habilita && (hab_run % DIV == DIV - 1);
        hab_run = (habilita && !carrega) ? hab_run + 1 : 0;
        m_novo  = 1;
        if (carrega) m_code = int'(valor_carga);
        else if (fire || tk) m_code = sentido ? (m_code + 1) % 32 : (m_code + 31) % 32;
        else m_novo = 0;
        #1;
        verifica("codigo", int'(codigo), m_code);
        verifica("novo", int'(novo), int'(m_novo));
    endtask

    task automatic ciclos(input int n);
        repeat (n) ciclo();
    endtask

    // Called just after an edge; asserts reset between edges and releases before the next.
    task automatic reset_assincrono();
        #2 rst_n = 1'b0;
        #1;
        verifica("reset_codigo", int'(codigo), 0);
        verifica("reset_novo", int'(novo), 0);
        modelo_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulsos;
        int base;
        int seg;
        modelo_reset();
        #3;
        verifica("reset_ini_codigo", int'(codigo), 0);
        verifica("reset_ini_novo", int'(novo), 0);
        #4 rst_n = 1'b1;

        // Reset mid-operation
        habilita = 1'b1;
        sentido  = 1'b1;
        ciclos(24);
        verifica("auto_ate_00110", int'(codigo), 6);
        reset_assincrono();
        ciclos(3);
        verifica("pos_reset_sem_tick", int'(codigo), 0);
        ciclo();
        verifica("pos_reset_primeiro_tick", int'(codigo), 1);

        // Auto up with wrap
        pulsos = 0;
        for (int i = 0; i < 128; i++) begin
            ciclo();
            if (novo) pulsos++;
        end
        verifica("pulsos_128", pulsos, 32);
        ciclos(12);

        // Down wrap
        carrega     = 1'b1;
        valor_carga = 5'b00000;
        ciclo();
        carrega = 1'b0;
        sentido = 1'b0;
        ciclos(4);
        verifica("desce_11111", int'(codigo), 31);
        ciclos(4);
        verifica("desce_11110", int'(codigo), 30);

        // Debounce: glitch, long hold, bouncy release
        habilita = 1'b0;
        sentido  = 1'b1;
        ciclos(10);
        base  = m_code;
        passo = 1'b1;
        ciclos(3);
        passo = 1'b0;
        ciclos(10);
        verifica("glitch_ignorado", int'(codigo), base);
        passo = 1'b1;
        ciclos(6);
        verifica("passo_antes_ed7", int'(codigo), base);
        ciclo();
        verifica("passo_ed7", int'(codigo), (base + 1) % 32);
        verifica("passo_ed7_novo", int'(novo), 1);
        ciclos(13);
        repeat (3) begin
            passo = 1'b0;
            ciclo();
            passo = 1'b1;
            ciclo();
        end
        passo = 1'b0;
        ciclos(12);
        verifica("soltura_sem_passo", int'(codigo), (base + 1) % 32);

        // Priority: load on the same edge as a tick and a debounced step
        passo = 1'b1;
        ciclos(2);
        carrega     = 1'b1;
        valor_carga = 5'b01010;
        ciclo();
        carrega  = 1'b0;
        habilita = 1'b1;
        ciclos(3);
        carrega     = 1'b1;
        valor_carga = 5'b10101;
        ciclo();
        verifica("prioridade_carga", int'(codigo), 21);
        verifica("prioridade_novo", int'(novo), 1);
        carrega = 1'b0;
        passo   = 1'b0;
        ciclo();
        verifica("prioridade_novo_fim", int'(novo), 0);
        ciclos(2);
        verifica("prescaler_reinicia", int'(codigo), 21);
        ciclo();
        verifica("prescaler_tick_apos_carga", int'(codigo), 22);

        // Step and tick on the same edge
        habilita = 1'b0;
        ciclos(12);
        passo = 1'b1;
        ciclos(2);
        carrega     = 1'b1;
        valor_carga = 5'b00011;
        ciclo();
        carrega  = 1'b0;
        habilita = 1'b1;
        ciclos(3);
        verifica("colisao_antes", int'(codigo), 3);
        ciclo();
        verifica("colisao_codigo", int'(codigo), 4);
        verifica("colisao_novo", int'(novo), 1);
        passo = 1'b0;
        ciclo();
        verifica("colisao_pulso_unico", int'(novo), 0);
        verifica("colisao_codigo_mantem", int'(codigo), 4);

        // Random stimulus
        seg = 0;
        for (int i = 0; i < 1500; i++) begin
            if (seg == 0) begin
                passo = 1'($urandom_range(0, 1));
                seg   = int'($urandom_range(1, 12));
            end
            seg--;
            habilita    = ($urandom_range(0, 3) != 0);
            sentido     = 1'($urandom_range(0, 1));
            carrega     = ($urandom_range(0, 40) == 0);
            valor_carga = 5'($urandom);
            if (i == 700) reset_assincrono();
            ciclo();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
